// File: rtl/paddle_input.sv
// paddle_input: synchronises and debounces the board buttons for the car game,
// producing one-cycle left/right step pulses with speed-selectable auto-repeat
// and a one-shot score-reset pulse.
module paddle_input #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 251750,
  parameter int unsigned REPEAT_DELAY    = 7552500,
  parameter int unsigned REPEAT_BASE     = 2517500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       left_in,
  input  logic       right_in,
  input  logic       reset_in,
  input  logic       speed_lsb,
  input  logic       speed_msb,
  output logic       left_step,
  output logic       right_step,
  output logic       score_reset,
  output logic [1:0] speed_sel
);

  localparam int unsigned NUM_IN  = 5;
  localparam int unsigned NUM_FSM = 3;
  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned MAX_CNT = (MAX_DR > REPEAT_BASE) ? MAX_DR : REPEAT_BASE;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT) + 1;

  // Repeat intervals for speed_sel 0..3 (k = 9, 6, 4, 3 over 9)
  localparam int unsigned INT_0 = (REPEAT_BASE * 9) / 9;
  localparam int unsigned INT_1 = (REPEAT_BASE * 6) / 9;
  localparam int unsigned INT_2 = (REPEAT_BASE * 4) / 9;
  localparam int unsigned INT_3 = (REPEAT_BASE * 3) / 9;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(REPEAT_DELAY - 1);

  // FSM index 0 = left, 1 = right, 2 = score reset (no auto-repeat)
  localparam logic [NUM_FSM-1:0] REP_EN = 3'b011;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESS   = 3'd1,
    HOLD    = 3'd2,
    REPEAT  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0][NUM_IN-1:0] sync_q;
  logic [NUM_IN-1:0]  raw_in;
  logic [NUM_IN-1:0]  sync_out;
  logic [NUM_FSM-1:0] btn;
  logic [1:0]         spd_prev;
  logic               spd_chg_c;
  logic [CNT_W-1:0]   interval;
  logic [CNT_W-1:0]   int_last;
  logic [NUM_FSM-1:0] fire_c;
  state_t             state [NUM_FSM];
  logic [CNT_W-1:0]   cnt   [NUM_FSM];

  assign raw_in    = {speed_msb, speed_lsb, reset_in, right_in, left_in};
  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign btn       = sync_out[2:0];
  assign speed_sel = sync_out[4:3];
  assign spd_chg_c = (speed_sel != spd_prev);
  assign int_last  = interval - CNT_W'(1);

  // Flop chain synchronising every raw button input
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
  end

  // Previous speed selection, for change detection
  always_ff @(posedge clk) begin
    if (rst) spd_prev <= 2'b00;
    else     spd_prev <= speed_sel;
  end

  // Repeat interval for the current speed
  always_comb begin
    interval = CNT_W'(INT_0);
    case (speed_sel)
      2'd1:    interval = CNT_W'(INT_1);
      2'd2:    interval = CNT_W'(INT_2);
      2'd3:    interval = CNT_W'(INT_3);
      default: interval = CNT_W'(INT_0);
    endcase
  end

  // Step request from each FSM in the cycle its count expires with the button still high
  always_comb begin
    fire_c = '0;
    for (int i = 0; i < NUM_FSM; i++) begin
      case (state[i])
        PRESS:   fire_c[i] = btn[i] && (cnt[i] == DEB_LAST);
        HOLD:    fire_c[i] = REP_EN[i] && btn[i] && (cnt[i] == HOLD_LAST);
        REPEAT:  fire_c[i] = btn[i] && !spd_chg_c && (cnt[i] == int_last);
        default: fire_c[i] = 1'b0;
      endcase
    end
  end

  // Debounce / hold / repeat / release state machines
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FSM; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FSM; i++) begin
        case (state[i])
          IDLE: begin
            if (btn[i]) begin
              state[i] <= PRESS;
              cnt[i]   <= '0;
            end
          end
          PRESS: begin
            if (!btn[i]) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else if (fire_c[i]) begin
              state[i] <= HOLD;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          HOLD: begin
            if (!btn[i]) begin
              state[i] <= RELEASE;
              cnt[i]   <= '0;
            end else if (fire_c[i]) begin
              state[i] <= REPEAT;
              cnt[i]   <= '0;
            end else if (REP_EN[i]) begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          REPEAT: begin
            if (!btn[i]) begin
              state[i] <= RELEASE;
              cnt[i]   <= '0;
            end else if (spd_chg_c || fire_c[i]) begin
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          RELEASE: begin
            if (btn[i]) begin
              // Score reset returns to HOLD so it cannot re-fire until a full release
              state[i] <= REP_EN[i] ? REPEAT : HOLD;
              cnt[i]   <= '0;
            end else if (cnt[i] == DEB_LAST) begin
              state[i] <= IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  // Registered outputs; simultaneous left/right steps cancel each other
  always_ff @(posedge clk) begin
    if (rst) begin
      left_step   <= 1'b0;
      right_step  <= 1'b0;
      score_reset <= 1'b0;
    end else begin
      left_step   <= fire_c[0] & ~fire_c[1];
      right_step  <= fire_c[1] & ~fire_c[0];
      score_reset <= fire_c[2];
    end
  end

endmodule

// File: tb/tb_paddle_input.sv
// tb_paddle_input: directed stimulus with a pulse scoreboard for paddle_input.
module tb_paddle_input;

  logic       clk;
  logic       rst;
  logic       left_in, right_in, reset_in, speed_lsb, speed_msb;
  logic       left_step, right_step, score_reset;
  logic [1:0] speed_sel;

  paddle_input #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_BASE    (9)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .left_in    (left_in),
    .right_in   (right_in),
    .reset_in   (reset_in),
    .speed_lsb  (speed_lsb),
    .speed_msb  (speed_msb),
    .left_step  (left_step),
    .right_step (right_step),
    .score_reset(score_reset),
    .speed_sel  (speed_sel)
  );

  typedef struct {
    int         cyc;
    logic [2:0] p;   // {score_reset, right_step, left_step}
  } exp_t;

  exp_t       expq[$];
  exp_t       e;
  logic [2:0] obs;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         lcnt = 0, rcnt = 0, scnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cyc = index of the most recent rising edge
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [2:0] p);
    exp_t x;
    x.cyc = c;
    x.p   = p;
    expq.push_back(x);
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Return on the falling edge after rising edge n; inputs set here are sampled at edge n+1
  task automatic goto(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Monitor: compare every observed pulse against the scoreboard, flag missed ones
  always @(negedge clk) begin
    obs = {score_reset, right_step, left_step};
    while (expq.size() > 0 && expq[0].cyc < cyc) begin
      e = expq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_pulse: got 000 expected %b at cycle %0d", e.p, e.cyc);
    end
    if (obs != 3'b000) begin
      lcnt += int'(left_step);
      rcnt += int'(right_step);
      scnt += int'(score_reset);
      vectors++;
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        e = expq.pop_front();
        if (obs != e.p) begin
          miscompares++;
          $display("FAIL pulse_pattern: got %b expected %b at cycle %0d", obs, e.p, cyc);
        end
      end else begin
        miscompares++;
        $display("FAIL unexpected_pulse: got %b expected 000 at cycle %0d", obs, cyc);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL timeout: got cycle %0d expected finish by 620", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b1;
    left_in = 1'b0; right_in = 1'b0; reset_in = 1'b0;
    speed_lsb = 1'b0; speed_msb = 1'b0;

    // Reset state
    goto(2); #1;
    check("rst_left_step", int'(left_step), 0);
    check("rst_right_step", int'(right_step), 0);
    check("rst_score_reset", int'(score_reset), 0);
    check("rst_speed_sel", int'(speed_sel), 0);
    goto(3); rst = 1'b0;

    // 1: left held from edge 10, released (sampled low) at edge 68
    push(16, 3'b001); push(36, 3'b001); push(45, 3'b001); push(54, 3'b001); push(63, 3'b001);
    goto(9);  left_in = 1'b1;
    goto(67); left_in = 1'b0;

    // 2: left high for 3 samples only -> no step
    goto(79); left_in = 1'b1;
    goto(82); left_in = 1'b0;
    goto(95); #1;
    check("t2_left_count", lcnt, 5);
    check("t2_right_count", rcnt, 0);
    check("t2_score_count", scnt, 0);

    // 3: right held from edge 100, speed 0->3 sampled at edge 150, released at 170
    push(106, 3'b010); push(126, 3'b010); push(135, 3'b010); push(144, 3'b010);
    push(155, 3'b010); push(158, 3'b010); push(161, 3'b010); push(164, 3'b010);
    push(167, 3'b010); push(170, 3'b010);
    goto(99);  right_in = 1'b1;
    goto(149); speed_lsb = 1'b1; speed_msb = 1'b1;
    goto(160); #1;
    check("t3_speed_sel_fast", int'(speed_sel), 3);
    goto(169); right_in = 1'b0;
    goto(174); speed_lsb = 1'b0; speed_msb = 1'b0;
    goto(180); #1;
    check("t3_speed_sel_slow", int'(speed_sel), 0);

    // 4: both held from edge 200 -> silent; right released at 250, left resumes
    push(253, 3'b001); push(262, 3'b001); push(271, 3'b001);
    goto(199); left_in = 1'b1; right_in = 1'b1;
    goto(249); right_in = 1'b0;
    goto(274); left_in = 1'b0;
    goto(290); #1;
    check("t4_left_count", lcnt, 8);
    check("t4_right_count", rcnt, 10);

    // 5: score reset held 100 cycles, then re-pressed
    push(306, 3'b100); push(426, 3'b100);
    goto(299); reset_in = 1'b1;
    goto(399); reset_in = 1'b0;
    goto(419); reset_in = 1'b1;
    goto(439); reset_in = 1'b0;
    goto(460); #1;
    check("t5_score_count", scnt, 2);

    // 6: rst pulse at edge 550 while left is in auto-repeat
    push(506, 3'b001); push(526, 3'b001); push(535, 3'b001); push(544, 3'b001);
    push(557, 3'b001); push(577, 3'b001); push(586, 3'b001);
    goto(499); left_in = 1'b1;
    goto(549); rst = 1'b1;
    goto(550); rst = 1'b0; #1;
    check("t6_rst_left_step", int'(left_step), 0);
    check("t6_rst_right_step", int'(right_step), 0);
    check("t6_rst_score_reset", int'(score_reset), 0);
    goto(589); left_in = 1'b0;

    goto(620); #1;
    check("final_pending_pulses", expq.size(), 0);
    check("final_left_count", lcnt, 15);
    check("final_right_count", rcnt, 10);
    check("final_score_count", scnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
